l2_cacheline_adaptor: RTL and testbench

- Responder on the L2 cache's downstream pmem interface; translates one 256-bit line read/write into a 4-beat 64-bit burst on the physical-memory port.
- Captures the request, aligns the address, serializes/deserializes beats, returns a single-cycle pmem_resp.
- Sits between l2_cache (pmem_* side) and main memory (burst side).

---
 rtl/l2_cacheline_adaptor.sv | 150 +++++++++++++++
 tb/tb_l2_cacheline_adaptor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor: bridges the L2 cache's single-line pmem interface to a
// 4-beat burst memory port. A 256-bit line read or write is captured in IDLE,
// then moved as num_beats beats of s_beat bits, one beat per cycle that resp_i
// is high, and completed with a single-cycle pmem_resp.
//
// Optional build macro L2_CLA_WRITE_POST_EN: writes are acknowledged one cycle
// after capture (WR_ACK) and then drained to memory in the background with no
// second completion pulse. Nothing new is captured until the drain finishes,
// so a read issued right after a posted write stays behind it.
//
// Handshake: pmem_read/pmem_write are levels held by the cache until it sees
// pmem_resp, and dropped in the following cycle. On the burst side, read_o or
// write_o is held for the whole burst and each cycle with resp_i=1 moves
// exactly one beat; resp_i=0 is a wait state that holds everything.
// fsm_state exposes the controller state for observation.
module l2_cacheline_adaptor #(
    parameter int s_offset  = 5,
    parameter int s_line    = 256,
    parameter int s_beat    = 64,
    parameter int num_beats = s_line / s_beat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [s_line-1:0] pmem_wdata,
    output logic [s_line-1:0] pmem_rdata,
    output logic              pmem_resp,
    input  logic [s_beat-1:0] burst_i,
    output logic [s_beat-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i,
    output logic [2:0]        fsm_state
);

    localparam int cnt_w = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        WR_BURST = 3'd2,
        DONE     = 3'd3,
        WR_ACK   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [cnt_w-1:0]  cnt;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wline_q;
    logic              beat_last;
    logic              capture;

    assign beat_last = (cnt == cnt_w'(num_beats - 1));
    assign capture   = (state == IDLE) && (pmem_read || pmem_write);

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: writes win over reads in IDLE; a burst ends on its last accepted beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pmem_write) begin
`ifdef L2_CLA_WRITE_POST_EN
                    state_next = WR_ACK;
`else
                    state_next = WR_BURST;
`endif
                end else if (pmem_read) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                if (resp_i && beat_last) state_next = DONE;
            end
            WR_BURST: begin
                if (resp_i && beat_last) begin
`ifdef L2_CLA_WRITE_POST_EN
                    state_next = IDLE;
`else
                    state_next = DONE;
`endif
                end
            end
            DONE:    state_next = IDLE;
            WR_ACK:  state_next = WR_BURST;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: burst strobes and completion pulse come straight from the state.
    always_comb begin
        read_o    = (state == RD_BURST);
        write_o   = (state == WR_BURST);
        pmem_resp = (state == DONE) || (state == WR_ACK);
        address_o = addr_q;
        burst_o   = '0;
        if (state == WR_BURST) begin
            burst_o = wline_q[int'(cnt) * s_beat +: s_beat];
        end
        fsm_state = state;
    end

    // Datapath: capture request in IDLE, then step the beat counter on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            addr_q     <= '0;
            wline_q    <= '0;
            pmem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        addr_q <= pmem_address & line_mask;
                        cnt    <= '0;
                        if (pmem_write) wline_q <= pmem_wdata;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        pmem_rdata[int'(cnt) * s_beat +: s_beat] <= burst_i;
                        cnt <= beat_last ? '0 : cnt + cnt_w'(1);
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        cnt <= beat_last ? '0 : cnt + cnt_w'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Bench for l2_cacheline_adaptor: per-cycle vectors of {inputs, expected outputs}
// applied at the falling edge, plus hand-written reset-abort and posted-write
// sequences.
module tb_l2_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
    logic [2:0]   fsm_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    l2_cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_i      (burst_i),
        .burst_o      (burst_o),
        .address_o    (address_o),
        .read_o       (read_o),
        .write_o      (write_o),
        .resp_i       (resp_i),
        .fsm_state    (fsm_state)
    );

    typedef struct {
        logic         rst;
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [63:0]  bi;
        logic         ri;
        logic         e_rd;
        logic         e_wr;
        logic         e_resp;
        logic [31:0]  e_addr;
        logic         chk_bo;
        logic [63:0]  e_bo;
        logic         chk_rd;
        logic [255:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] C1 = 64'hC1C1_0000_0000_0001;
    localparam logic [63:0] C2 = 64'hC2C2_0000_0000_0002;
    localparam logic [63:0] C3 = 64'hC3C3_0000_0000_0003;
    localparam logic [63:0] C4 = 64'hC4C4_0000_0000_0004;
    localparam logic [63:0] G  = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] D0 = 64'hD0D0_0000_AAAA_0000;
    localparam logic [63:0] D1 = 64'hD1D1_1111_BBBB_1111;
    localparam logic [63:0] D2 = 64'hD2D2_2222_CCCC_2222;
    localparam logic [63:0] D3 = 64'hD3D3_3333_EEEE_3333;
    localparam logic [255:0] LINE1 = {B4, B3, B2, B1};
    localparam logic [255:0] LINEC = {C4, C3, C2, C1};
    localparam logic [255:0] WL    = {D3, D2, D1, D0};
    localparam logic [255:0] WL2   = {D0, D1, D2, D3};

    function automatic vec_t v(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [255:0] wdata, input logic [63:0] bi, input logic ri,
                               input logic e_rd, input logic e_wr, input logic e_resp,
                               input logic [31:0] e_addr, input logic chk_bo, input logic [63:0] e_bo,
                               input logic chk_rd, input logic [255:0] e_rdata);
        vec_t r;
        r.rst = 1'b0;   r.rd = rd;         r.wr = wr;          r.addr = addr;
        r.wdata = wdata; r.bi = bi;        r.ri = ri;          r.e_rd = e_rd;
        r.e_wr = e_wr;  r.e_resp = e_resp; r.e_addr = e_addr;  r.chk_bo = chk_bo;
        r.e_bo = e_bo;  r.chk_rd = chk_rd; r.e_rdata = e_rdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t x, input string tag);
        @(negedge clk);
        rst          = x.rst;
        pmem_read    = x.rd;
        pmem_write   = x.wr;
        pmem_address = x.addr;
        pmem_wdata   = x.wdata;
        burst_i      = x.bi;
        resp_i       = x.ri;
        #1;
        chk({tag, ".read_o"}, 256'(read_o), 256'(x.e_rd));
        chk({tag, ".write_o"}, 256'(write_o), 256'(x.e_wr));
        chk({tag, ".pmem_resp"}, 256'(pmem_resp), 256'(x.e_resp));
        if (x.e_rd || x.e_wr) chk({tag, ".address_o"}, 256'(address_o), 256'(x.e_addr));
        if (x.chk_bo) chk({tag, ".burst_o"}, 256'(burst_o), 256'(x.e_bo));
        if (x.chk_rd) chk({tag, ".pmem_rdata"}, pmem_rdata, x.e_rdata);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout got=running want=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        vec_t r;

        // Clock/reset block
        rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0;
        pmem_wdata = '0; burst_i = '0; resp_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.read_o", 256'(read_o), 256'(0));
        chk("reset.write_o", 256'(write_o), 256'(0));
        chk("reset.pmem_resp", 256'(pmem_resp), 256'(0));
        chk("reset.address_o", 256'(address_o), 256'(0));
        chk("reset.burst_o", 256'(burst_o), 256'(0));
        chk("reset.pmem_rdata", pmem_rdata, 256'(0));
        chk("reset.state", 256'(fsm_state), 256'(0));

        // Zero-wait read at 0x1234 -> line 0x1220
        vecs.push_back(v(1,0,32'h1234,0,0,0,  0,0,0,0,            0,0, 0,0));
        vecs.push_back(v(1,0,32'h1234,0,B1,1, 1,0,0,32'h1220,     0,0, 0,0));
        vecs.push_back(v(1,0,32'h1234,0,B2,1, 1,0,0,32'h1220,     0,0, 0,0));
        vecs.push_back(v(1,0,32'h1234,0,B3,1, 1,0,0,32'h1220,     0,0, 0,0));
        vecs.push_back(v(1,0,32'h1234,0,B4,1, 1,0,0,32'h1220,     0,0, 0,0));
        vecs.push_back(v(1,0,32'h1234,0,0,0,  0,0,1,0,            0,0, 1,LINE1));
        vecs.push_back(v(0,0,0,0,B1,1,        0,0,0,0,            0,0, 1,LINE1));
        vecs.push_back(v(0,0,0,0,0,0,         0,0,0,0,            0,0, 1,LINE1));
        // Read with wait states: resp_i 1,0,0,1,1,0,1
        vecs.push_back(v(1,0,32'h5F,0,0,0,    0,0,0,0,            0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,C1,1,   1,0,0,32'h40,       0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,G,0,    1,0,0,32'h40,       0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,G,0,    1,0,0,32'h40,       0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,C2,1,   1,0,0,32'h40,       0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,C3,1,   1,0,0,32'h40,       0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,G,0,    1,0,0,32'h40,       0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,C4,1,   1,0,0,32'h40,       0,0, 0,0));
        vecs.push_back(v(1,0,32'h5F,0,0,0,    0,0,1,0,            0,0, 1,LINEC));
        vecs.push_back(v(0,0,0,0,0,0,         0,0,0,0,            0,0, 1,LINEC));
`ifndef L2_CLA_WRITE_POST_EN
        // Write at 0x8000_00FF -> 0x8000_00E0; wdata changes after capture must not matter
        vecs.push_back(v(0,1,32'h8000_00FF,WL,0,0,  0,0,0,0,              0,0,  0,0));
        vecs.push_back(v(0,1,32'h0,~WL,0,1,         0,1,0,32'h8000_00E0,  1,D0, 0,0));
        vecs.push_back(v(0,1,32'h0,~WL,0,0,         0,1,0,32'h8000_00E0,  1,D1, 0,0));
        vecs.push_back(v(0,1,32'h0,~WL,0,1,         0,1,0,32'h8000_00E0,  1,D1, 0,0));
        vecs.push_back(v(0,1,32'h0,~WL,0,1,         0,1,0,32'h8000_00E0,  1,D2, 0,0));
        vecs.push_back(v(0,1,32'h0,~WL,0,1,         0,1,0,32'h8000_00E0,  1,D3, 0,0));
        vecs.push_back(v(0,1,32'h0,~WL,0,0,         0,0,1,0,              1,0,  1,LINEC));
        vecs.push_back(v(0,0,0,0,0,0,               0,0,0,0,              1,0,  0,0));
        // Simultaneous read and write: write first, then read at new address
        vecs.push_back(v(1,1,32'h100,WL2,0,0,  0,0,0,0,        0,0,  0,0));
        vecs.push_back(v(1,1,32'h100,WL2,0,1,  0,1,0,32'h100,  1,D3, 0,0));
        vecs.push_back(v(1,1,32'h100,WL2,0,1,  0,1,0,32'h100,  1,D2, 0,0));
        vecs.push_back(v(1,1,32'h100,WL2,0,1,  0,1,0,32'h100,  1,D1, 0,0));
        vecs.push_back(v(1,1,32'h100,WL2,0,1,  0,1,0,32'h100,  1,D0, 0,0));
        vecs.push_back(v(1,1,32'h100,WL2,0,0,  0,0,1,0,        0,0,  0,0));
        vecs.push_back(v(1,0,32'h2A8,0,0,0,    0,0,0,0,        0,0,  0,0));
        vecs.push_back(v(1,0,32'h2A8,0,B1,1,   1,0,0,32'h2A0,  1,0,  0,0));
        vecs.push_back(v(1,0,32'h2A8,0,B2,1,   1,0,0,32'h2A0,  0,0,  0,0));
        vecs.push_back(v(1,0,32'h2A8,0,B3,1,   1,0,0,32'h2A0,  0,0,  0,0));
        vecs.push_back(v(1,0,32'h2A8,0,B4,1,   1,0,0,32'h2A0,  0,0,  0,0));
        vecs.push_back(v(1,0,32'h2A8,0,0,0,    0,0,1,0,        0,0,  1,LINE1));
        vecs.push_back(v(0,0,0,0,0,0,          0,0,0,0,        0,0,  1,LINE1));
`endif

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Reset during beat 2 of a read: burst aborts, no pmem_resp, later read works
        apply(v(1,0,32'h300,0,0,0,   0,0,0,0,       0,0, 0,0), "rst_mid.req");
        apply(v(1,0,32'h300,0,B4,1,  1,0,0,32'h300, 0,0, 0,0), "rst_mid.beat1");
        r = v(1,0,32'h300,0,B3,1,    1,0,0,32'h300, 0,0, 0,0);
        r.rst = 1'b1;
        apply(r, "rst_mid.beat2");
        apply(v(0,0,0,0,B2,1,        0,0,0,0,       0,0, 1,0), "rst_mid.after");
        chk("rst_mid.state", 256'(fsm_state), 256'(0));
        apply(v(0,0,0,0,B1,1,        0,0,0,0,       0,0, 1,0), "rst_mid.idle1");
        apply(v(1,0,32'h3DF,0,0,0,   0,0,0,0,       0,0, 1,0), "rst_mid.idle2");
        apply(v(1,0,32'h3DF,0,C1,1,  1,0,0,32'h3C0, 0,0, 0,0), "rst_mid.rb1");
        apply(v(1,0,32'h3DF,0,C2,1,  1,0,0,32'h3C0, 0,0, 0,0), "rst_mid.rb2");
        apply(v(1,0,32'h3DF,0,C3,1,  1,0,0,32'h3C0, 0,0, 0,0), "rst_mid.rb3");
        apply(v(1,0,32'h3DF,0,C4,1,  1,0,0,32'h3C0, 0,0, 0,0), "rst_mid.rb4");
        apply(v(1,0,32'h3DF,0,0,0,   0,0,1,0,       0,0, 1,LINEC), "rst_mid.done");
        apply(v(0,0,0,0,0,0,         0,0,0,0,       0,0, 1,LINEC), "rst_mid.end");

`ifdef L2_CLA_WRITE_POST_EN
        // Posted write: ack at T+1, read raised at ack waits for the 4-beat drain
        apply(v(0,1,32'h50F,WL,0,0,  0,0,0,0,        0,0,  0,0), "post.req");
        apply(v(0,1,32'h50F,WL,0,0,  0,0,1,0,        1,0,  0,0), "post.ack");
        apply(v(1,0,32'h640,~WL,0,1, 0,1,0,32'h500,  1,D0, 0,0), "post.d0");
        apply(v(1,0,32'h640,~WL,0,1, 0,1,0,32'h500,  1,D1, 0,0), "post.d1");
        apply(v(1,0,32'h640,~WL,0,1, 0,1,0,32'h500,  1,D2, 0,0), "post.d2");
        apply(v(1,0,32'h640,~WL,0,1, 0,1,0,32'h500,  1,D3, 0,0), "post.d3");
        apply(v(1,0,32'h640,0,0,0,   0,0,0,0,        1,0,  0,0), "post.idle");
        apply(v(1,0,32'h640,0,B1,1,  1,0,0,32'h640,  0,0,  0,0), "post.rb1");
        apply(v(1,0,32'h640,0,B2,1,  1,0,0,32'h640,  0,0,  0,0), "post.rb2");
        apply(v(1,0,32'h640,0,B3,1,  1,0,0,32'h640,  0,0,  0,0), "post.rb3");
        apply(v(1,0,32'h640,0,B4,1,  1,0,0,32'h640,  0,0,  0,0), "post.rb4");
        apply(v(1,0,32'h640,0,0,0,   0,0,1,0,        0,0,  1,LINE1), "post.done");
        apply(v(0,0,0,0,0,0,         0,0,0,0,        0,0,  1,LINE1), "post.end");
`endif

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
